instr_encoder: RTL and testbench
================================

# instr_encoder

Pipelined RV32I instruction encoder: the inverse of the main decoder. It accepts instruction fields (kind, registers, funct, immediate) over a valid/ready stream and emits packed 32-bit machine words for the supported opcodes: lw, sw, R-type, beq, and optionally jal. It is used by the instruction-memory loader and by bench program generators. Malformed requests are replaced by a NOP and flagged.

## Interface
Parameters:
- ERR_CNT_W, 8, width of the saturating error counter

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept a request
- in_kind  in  3  0=LW, 1=SW, 2=RTYPE, 3=BEQ, 4=JAL; others are illegal
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_funct3  in  3  used for RTYPE only
- in_funct7  in  7  used for RTYPE only
- in_imm  in  32  signed byte-offset immediate
- out_valid  out  1  encoded word valid
- out_ready  in  1  downstream accepts the word
- out_instr  out  32  encoded instruction
- out_err  out  1  request was illegal; out_instr is the NOP
- err_count  out  ERR_CNT_W  saturating count of errored words delivered

## Operation
- Stage 1 (S1):
  - registers the fields.
  - computes the legality check and forced fields.
- Stage 2 (S2):
  - registers the packed word and the error flag.
  - drives the out_* ports directly from flops.
- Forced fields:
  - LW: op 0000011, funct3 010.
  - SW: op 0100011, funct3 010.
  - RTYPE: op 0110011, funct3 and funct7 from the inputs.
  - BEQ: op 1100011, funct3 000.
  - JAL: op 1101111.
- Immediate legality, checked on the full 32-bit signed in_imm:
  - I and S formats: −2048..2047.
  - B format: −4096..4094 and even.
  - J format: −2^20..2^20−2 and even.
  - RTYPE ignores in_imm.
- An illegal kind or an out-of-range/odd immediate produces out_instr = 32'h0000_0013 (addi x0,x0,0) with out_err = 1.
- Field packing follows the RV32I I/S/B/J layouts exactly; rd is unused in S/B, and rs1/rs2 are unused in J.
- err_count increments on every out_valid & out_ready & out_err and saturates at 2^ERR_CNT_W−1.

## Timing
- Reset values: in_ready=1 (during and after reset), out_valid=0, out_instr=0, out_err=0, err_count=0, internal stage valids=0.
- Latency: a request accepted at edge N is presented with out_valid=1 after edge N+1.
- Throughput: one word per cycle while out_ready=1.
- Handshake rules:
  - transfer occurs when valid & ready are both high at the rising edge.
  - while out_valid & !out_ready, out_instr and out_err are held stable.
  - out_valid never drops without a transfer.
- Stall: S2 loads when it is empty or being consumed; S1 advances under the same condition.
- in_ready = !S1_valid | S1_advance. Combinational from out_ready is permitted, and there are no combinational paths from in_* to out_*.
- Full pipeline: two requests are held, in_ready=0, and no request is dropped or reordered.
- Simultaneous accept and deliver in one cycle is legal and keeps the pipeline full.
- Reset asserted mid-stream: in-flight words are discarded, and err_count clears.

## Configuration
- INSTR_ENCODER_JAL_EN defined: kind 4 encodes jal rd, imm in J format with the J-range check.
- Undefined: kind 4 is illegal and yields NOP with out_err=1; the J-format packing logic is absent.

## Structure
- Shared package riscv_pkg holds:
  - opcode constants OP_LW, OP_SW, OP_R, OP_BEQ, OP_JAL;
  - the instr_kind_t enum (3 bits);
  - the ImmSrc format codes (I=00, S=01, B=10, J=11), matching the decoder encoding;
  - the NOP constant 32'h0000_0013.
- Sub-module imm_pack is combinational:
  - inputs: format and 32-bit imm;
  - outputs: the scattered immediate bits over a 32-bit word, plus an in_range flag.

## Test plan
- LW rd=5 rs1=2 imm=8 -> out_instr 0x00812283, out_err=0, out_valid one edge after accept.
- SW rs1=3 rs2=6 imm=12 -> 0x0061A623. RTYPE rd=7 rs1=5 rs2=6 f3=0 f7=0 -> 0x006283B3.
- BEQ rs1=4 rs2=4 imm=−8 -> 0xFE420CE3. BEQ imm=3 (odd) -> 0x00000013, out_err=1, err_count 0->1 on delivery.
- Back-to-back stream of 4 requests with out_ready=0 for 3 cycles:
  - in_ready falls once 2 are held;
  - out_instr stays stable while stalled;
  - all 4 words arrive in order after release.
- Illegal kind 6, and SW imm=2048 -> NOP with err=1. Drive 300 errors -> err_count saturates at 255.
- Assert reset with both stages full -> out_valid=0 and err_count=0 immediately; the first request after release is encoded correctly.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants and types for the instruction encoder.
// Optional jal support is selected by INSTR_ENCODER_JAL_EN.
package riscv_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        KIND_LW    = 3'd0,
        KIND_SW    = 3'd1,
        KIND_RTYPE = 3'd2,
        KIND_BEQ   = 3'd3,
        KIND_JAL   = 3'd4
    } instr_kind_t;

    // Same code points as the decoder's ImmSrc
    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_t;

    function automatic logic in_span(input logic [31:0] v, input int lo, input int hi);
        return ($signed(v) >= lo) && ($signed(v) <= hi);
    endfunction

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// Combinational immediate scatter for the I/S/B/J layouts plus range check.
// The J layout exists only when INSTR_ENCODER_JAL_EN is defined.
module imm_pack
    import riscv_pkg::*;
(
    input  imm_src_t    fmt,
    input  logic [31:0] imm,
    output logic [31:0] imm_bits,
    output logic        in_range
);

    always_comb begin
        imm_bits = '0;
        in_range = 1'b0;
        case (fmt)
            IMM_I: begin
                imm_bits[31:20] = imm[11:0];
                in_range        = in_span(imm, -2048, 2047);
            end
            IMM_S: begin
                imm_bits[31:25] = imm[11:5];
                imm_bits[11:7]  = imm[4:0];
                in_range        = in_span(imm, -2048, 2047);
            end
            IMM_B: begin
                imm_bits[31]    = imm[12];
                imm_bits[30:25] = imm[10:5];
                imm_bits[11:8]  = imm[4:1];
                imm_bits[7]     = imm[11];
                in_range        = in_span(imm, -4096, 4094) && !imm[0];
            end
`ifdef INSTR_ENCODER_JAL_EN
            IMM_J: begin
                imm_bits[31]    = imm[20];
                imm_bits[30:21] = imm[10:1];
                imm_bits[20]    = imm[11];
                imm_bits[19:12] = imm[19:12];
                in_range        = in_span(imm, -1048576, 1048574) && !imm[0];
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage RV32I encoder: S1 holds request fields, S2 holds the packed word.
// Define INSTR_ENCODER_JAL_EN to make kind 4 encode jal; otherwise it is illegal.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_kind,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [2:0]           in_funct3,
    input  logic [6:0]           in_funct7,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic        s1_valid;
    logic [2:0]  s1_kind;
    logic [4:0]  s1_rd, s1_rs1, s1_rs2;
    logic [2:0]  s1_f3;
    logic [6:0]  s1_f7;
    logic [31:0] s1_imm;

    logic        s2_load, s1_adv, in_fire;
    imm_src_t    fmt;
    logic [31:0] imm_bits, word, enc_instr;
    logic        in_range, legal;

    assign s2_load  = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_load;
    assign in_ready = !s1_valid || s1_adv;
    assign in_fire  = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_kind  <= '0;
            s1_rd    <= '0;
            s1_rs1   <= '0;
            s1_rs2   <= '0;
            s1_f3    <= '0;
            s1_f7    <= '0;
            s1_imm   <= '0;
        end else begin
            if (in_ready)
                s1_valid <= in_valid;
            if (in_fire) begin
                s1_kind <= in_kind;
                s1_rd   <= in_rd;
                s1_rs1  <= in_rs1;
                s1_rs2  <= in_rs2;
                s1_f3   <= in_funct3;
                s1_f7   <= in_funct7;
                s1_imm  <= in_imm;
            end
        end
    end

    // Format select kept apart from packing so imm_pack sits on an acyclic path
    always_comb begin
        fmt = IMM_I;
        case (s1_kind)
            KIND_SW:  fmt = IMM_S;
            KIND_BEQ: fmt = IMM_B;
`ifdef INSTR_ENCODER_JAL_EN
            KIND_JAL: fmt = IMM_J;
`endif
            default:  fmt = IMM_I;
        endcase
    end

    imm_pack u_imm_pack (
        .fmt      (fmt),
        .imm      (s1_imm),
        .imm_bits (imm_bits),
        .in_range (in_range)
    );

    always_comb begin
        word  = NOP;
        legal = 1'b0;
        case (s1_kind)
            KIND_LW: begin
                word  = imm_bits | {12'b0, s1_rs1, F3_WORD, s1_rd, OP_LW};
                legal = in_range;
            end
            KIND_SW: begin
                word  = imm_bits | {7'b0, s1_rs2, s1_rs1, F3_WORD, 5'b0, OP_SW};
                legal = in_range;
            end
            KIND_RTYPE: begin
                word  = {s1_f7, s1_rs2, s1_rs1, s1_f3, s1_rd, OP_R};
                legal = 1'b1;
            end
            KIND_BEQ: begin
                word  = imm_bits | {7'b0, s1_rs2, s1_rs1, F3_BEQ, 5'b0, OP_BEQ};
                legal = in_range;
            end
`ifdef INSTR_ENCODER_JAL_EN
            KIND_JAL: begin
                word  = imm_bits | {20'b0, s1_rd, OP_JAL};
                legal = in_range;
            end
`endif
            default: legal = 1'b0;
        endcase
        enc_instr = legal ? word : NOP;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_err   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_instr <= enc_instr;
                out_err   <= !legal;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err_count <= '0;
        else if (out_valid && out_ready && out_err && !(&err_count))
            err_count <= err_count + 1'b1;
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed vector bench for instr_encoder: table of encodings plus stall,
// saturation and mid-stream reset sequences.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_kind;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [7:0]  err_count;

    int checks   = 0;
    int failures = 0;
    int model_err = 0;

    typedef struct {
        logic [2:0]  kind;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    instr_encoder #(.ERR_CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kind   (in_kind),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_kind   = v.kind;
        in_rd     = v.rd;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_funct3 = v.f3;
        in_funct7 = v.f7;
        in_imm    = v.imm;
    endtask

    // Single request with out_ready high; entered and left at posedge+1
    task automatic run_vec(input int i);
        drive(vecs[i]);
        in_valid = 1'b1;
        #1;
        chk($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk($sformatf("v%0d_latency", i), {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
        chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, 32'd1);
        chk($sformatf("v%0d_instr", i), out_instr, vecs[i].exp_instr);
        chk($sformatf("v%0d_err", i), {31'b0, out_err}, {31'b0, vecs[i].exp_err});
        if (vecs[i].exp_err && model_err < 255) model_err++;
        @(posedge clk); #1;
        chk($sformatf("v%0d_err_count", i), {24'b0, err_count}, model_err);
    endtask

    initial begin
        int sent, got, accepted, c;
        logic acc, dlv;
        logic [31:0] cur;

        vecs[0]  = '{3'd0, 5'd5, 5'd2, 5'd0, 3'd0, 7'd0, 32'd8,          32'h0081_2283, 1'b0};
        vecs[1]  = '{3'd1, 5'd0, 5'd3, 5'd6, 3'd0, 7'd0, 32'd12,         32'h0061_A623, 1'b0};
        vecs[2]  = '{3'd2, 5'd7, 5'd5, 5'd6, 3'd0, 7'd0, 32'd0,          32'h0062_83B3, 1'b0};
        vecs[3]  = '{3'd3, 5'd0, 5'd4, 5'd4, 3'd0, 7'd0, 32'hFFFF_FFF8,  32'hFE42_0CE3, 1'b0};
        vecs[4]  = '{3'd3, 5'd0, 5'd4, 5'd4, 3'd0, 7'd0, 32'd3,          32'h0000_0013, 1'b1};
        vecs[5]  = '{3'd6, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0,          32'h0000_0013, 1'b1};
        vecs[6]  = '{3'd1, 5'd0, 5'd3, 5'd6, 3'd0, 7'd0, 32'd2048,       32'h0000_0013, 1'b1};
        vecs[7]  = '{3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800,  32'h8000_2083, 1'b0};
        vecs[8]  = '{3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047,       32'h7FF0_2003, 1'b0};
        vecs[9]  = '{3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094,       32'h7E00_0FE3, 1'b0};
        vecs[10] = '{3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096,       32'h0000_0013, 1'b1};
        vecs[11] = '{3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F000,  32'h8000_0063, 1'b0};
`ifdef INSTR_ENCODER_JAL_EN
        vecs[12] = '{3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8,          32'h0080_006F, 1'b0};
`else
        vecs[12] = '{3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8,          32'h0000_0013, 1'b1};
`endif
        vecs[13] = '{3'd2, 5'd1, 5'd2, 5'd3, 3'd7, 7'h20, 32'd0,         32'h4031_70B3, 1'b0};
        vecs[14] = '{3'd7, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0,          32'h0000_0013, 1'b1};

        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(vecs[0]);
        #2;
        chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr,          32'd0);
        chk("rst_out_err",   {31'b0, out_err},   32'd0);
        chk("rst_err_count", {24'b0, err_count}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NVEC; i++)
            run_vec(i);

        // Back-to-back stream with a three-cycle downstream stall once full
        sent = 0;
        got  = 0;
        for (c = 0; c < 30 && got < 4; c++) begin
            out_ready = (c >= 2 && c < 5) ? 1'b0 : 1'b1;
            if (sent < 4) begin
                drive(vecs[sent]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c >= 2 && c < 5) begin
                chk("stall_in_ready", {31'b0, in_ready},  32'd0);
                chk("stall_valid",    {31'b0, out_valid}, 32'd1);
                chk("stall_hold",     out_instr,          vecs[0].exp_instr);
            end
            acc = in_valid && in_ready;
            dlv = out_valid && out_ready;
            cur = out_instr;
            if (dlv) begin
                chk($sformatf("stream_order%0d", got), cur, vecs[got].exp_instr);
                got++;
            end
            if (acc) sent++;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", got, 32'd4);
        repeat (2) @(posedge clk);
        #1;

        // Saturate the error counter with a stream of illegal kinds
        drive(vecs[5]);
        in_valid = 1'b1;
        accepted = 0;
        for (c = 0; c < 400 && accepted < 300; c++) begin
            if (accepted == 150)
                chk("sat_mid_count", {24'b0, err_count}, model_err);
            acc = in_ready;
            dlv = out_valid && out_err;
            if (dlv && model_err < 255) model_err++;
            if (acc) accepted++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (out_valid && out_err && model_err < 255) model_err++;
            @(posedge clk); #1;
        end
        chk("sat_accepted",  accepted,            32'd300);
        chk("sat_model",     {24'b0, err_count}, model_err);
        chk("sat_max",       {24'b0, err_count}, 32'd255);

        // Fill both stages, then reset mid-stream
        out_ready = 1'b0;
        drive(vecs[5]);
        in_valid = 1'b1;
        accepted = 0;
        for (c = 0; c < 10 && accepted < 2; c++) begin
            if (in_ready) accepted++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("full_accepted",  accepted,           32'd2);
        chk("full_valid",     {31'b0, out_valid}, 32'd1);
        chk("full_in_ready",  {31'b0, in_ready},  32'd0);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid",     {31'b0, out_valid}, 32'd0);
        chk("mid_rst_err_count", {24'b0, err_count}, 32'd0);
        chk("mid_rst_in_ready",  {31'b0, in_ready},  32'd1);
        model_err = 0;
        @(posedge clk); #1;
        reset     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        run_vec(0);
        run_vec(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
